// File: rtl/sccb_reader.sv
// sccb_reader: SCCB master that reads one 8-bit register from an OV camera.
// One read is a 2-phase write (ID, sub-address), STOP, a one-segment idle gap,
// then a 2-phase read (ID|1, data + NA), STOP. Every bus segment is four
// quarters of QUARTER clk cycles. scl/sda are registered from the next-state
// values, so they only move on quarter boundaries.
module sccb_reader #(
    parameter int QUARTER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  dev_id,
    input  logic [7:0]  sub_addr,
    output logic        scl,
    inout  wire         sda,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        ack_err,
    output logic [31:0] debug_out
);

    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);
    localparam logic [QW-1:0] Q_ZERO = {QW{1'b0}};
    localparam logic [QW-1:0] Q_ONE  = QW'(1);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START_W = 4'd1,
        ST_TX_ID   = 4'd2,
        ST_TX_SUB  = 4'd3,
        ST_STOP_W  = 4'd4,
        ST_GAP     = 4'd5,
        ST_START_R = 4'd6,
        ST_TX_IDR  = 4'd7,
        ST_RX_DATA = 4'd8,
        ST_STOP_R  = 4'd9,
        ST_DONE    = 4'd10
    } state_t;

    // Segment that follows a finished segment (byte states only after bit 8).
    function automatic state_t follow(input state_t cur);
        state_t nxt;
        case (cur)
            ST_START_W: nxt = ST_TX_ID;
            ST_TX_ID:   nxt = ST_TX_SUB;
            ST_TX_SUB:  nxt = ST_STOP_W;
            ST_STOP_W:  nxt = ST_GAP;
            ST_GAP:     nxt = ST_START_R;
            ST_START_R: nxt = ST_TX_IDR;
            ST_TX_IDR:  nxt = ST_RX_DATA;
            ST_RX_DATA: nxt = ST_STOP_R;
            ST_STOP_R:  nxt = ST_DONE;
            default:    nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    state_t          state_r, state_s;
    logic [QW-1:0]   qcnt_r, qcnt_s;
    logic [1:0]      quarter_r, quarter_s;
    logic [3:0]      bit_cnt_r, bit_cnt_s;
    logic [7:0]      id_q_r, sub_q_r, shift_r, rdata_r;
    logic            busy_r, done_r, ack_err_r;
    logic            scl_r, sda_oe_r;
    logic            accept_s, quarter_end_s, seg_end_s, sample_s, is_byte_s;
    logic            is_tx_s;
    logic            scl_s, sda_rel_s;
    logic [7:0]      tx_byte_s;

    assign quarter_end_s = (qcnt_r == Q_LAST);
    assign seg_end_s     = quarter_end_s && (quarter_r == 2'd3);
    assign sample_s      = quarter_end_s && (quarter_r == 2'd2);
    assign is_tx_s       = (state_r == ST_TX_ID) || (state_r == ST_TX_SUB) ||
                           (state_r == ST_TX_IDR);
    assign is_byte_s     = is_tx_s || (state_r == ST_RX_DATA);

    // Next state and quarter/bit counters.
    always_comb begin
        state_s   = state_r;
        qcnt_s    = qcnt_r;
        quarter_s = quarter_r;
        bit_cnt_s = bit_cnt_r;
        accept_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s  = 1'b1;
                    state_s   = ST_START_W;
                    qcnt_s    = Q_ZERO;
                    quarter_s = 2'd0;
                    bit_cnt_s = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_s   = ST_IDLE;
                qcnt_s    = Q_ZERO;
                quarter_s = 2'd0;
                bit_cnt_s = 4'd0;
            end
            default: begin
                if (quarter_end_s) begin
                    qcnt_s    = Q_ZERO;
                    quarter_s = quarter_r + 2'd1;
                end else begin
                    qcnt_s = qcnt_r + Q_ONE;
                end
                if (seg_end_s) begin
                    if (is_byte_s && (bit_cnt_r != 4'd8)) begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end else begin
                        bit_cnt_s = 4'd0;
                        state_s   = follow(state_r);
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r;
                end
            end
        endcase
    end

    // Bus levels for the upcoming cycle, derived from the next segment/quarter.
    always_comb begin
        scl_s     = 1'b1;
        sda_rel_s = 1'b1;
        tx_byte_s = id_q_r;
        case (state_s)
            ST_TX_SUB: tx_byte_s = sub_q_r;
            ST_TX_IDR: tx_byte_s = id_q_r | 8'h01;
            default:   tx_byte_s = id_q_r;
        endcase
        case (state_s)
            ST_START_W, ST_START_R: begin
                scl_s     = (quarter_s != 2'd3);
                sda_rel_s = (quarter_s == 2'd0);
            end
            ST_TX_ID, ST_TX_SUB, ST_TX_IDR: begin
                scl_s = quarter_s[1];
                if (bit_cnt_s == 4'd8) begin
                    sda_rel_s = 1'b1;
                end else begin
                    sda_rel_s = tx_byte_s[3'd7 - bit_cnt_s[2:0]];
                end
            end
            ST_RX_DATA: begin
                scl_s     = quarter_s[1];
                sda_rel_s = 1'b1;
            end
            ST_STOP_W, ST_STOP_R: begin
                scl_s     = (quarter_s != 2'd0);
                sda_rel_s = quarter_s[1];
            end
            default: begin
                scl_s     = 1'b1;
                sda_rel_s = 1'b1;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            qcnt_r    <= Q_ZERO;
            quarter_r <= 2'd0;
            bit_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_s;
            qcnt_r    <= qcnt_s;
            quarter_r <= quarter_s;
            bit_cnt_r <= bit_cnt_s;
        end
    end

    // Registered bus drivers; reset releases the bus at once without a STOP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_r    <= 1'b1;
            sda_oe_r <= 1'b0;
        end else begin
            scl_r    <= scl_s;
            sda_oe_r <= ~sda_rel_s;
        end
    end

    // Transaction latches, ACK/data sampling and completion handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_q_r    <= 8'h00;
            sub_q_r   <= 8'h00;
            shift_r   <= 8'h00;
            rdata_r   <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            done_r <= (state_s == ST_DONE);
            if (accept_s) begin
                id_q_r    <= dev_id & 8'hFE;
                sub_q_r   <= sub_addr;
                busy_r    <= 1'b1;
                ack_err_r <= 1'b0;
            end else if (state_s == ST_DONE) begin
                rdata_r <= shift_r;
                busy_r  <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (sample_s && is_tx_s && (bit_cnt_r == 4'd8) && (sda == 1'b1)) begin
                ack_err_r <= 1'b1;
            end else begin
                ack_err_r <= ack_err_r & ~accept_s;
            end
            if (sample_s && (state_r == ST_RX_DATA) && (bit_cnt_r != 4'd8)) begin
                shift_r <= {shift_r[6:0], (sda == 1'b1)};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    assign sda       = sda_oe_r ? 1'b0 : 1'bz;
    assign scl       = scl_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign rdata     = rdata_r;
    assign ack_err   = ack_err_r;
    assign debug_out = {state_r, bit_cnt_r, id_q_r, sub_q_r, rdata_r};

endmodule

// File: tb/tb_sccb_reader.sv
// Testbench for sccb_reader: behavioural SCCB slave with a register file,
// bus event monitor (START/STOP/9-bit frames, SCL high time) and randomised reads.
module tb_sccb_reader;
    localparam int Q        = 4;
    localparam int LAT      = 164 * Q;
    localparam int EV_START = 32'h100 << 4;
    localparam int EV_STOP  = 32'h200 << 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  dev_id, sub_addr, rdata;
    logic        scl, busy, done, ack_err;
    logic [31:0] debug_out;
    wire         sda;

    logic        slave_low = 1'b0;
    logic        ack_en;
    logic [7:0]  mem [256];
    logic [7:0]  last_rdata;
    int          mon_q[$];
    int          proto_err = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // model state
    logic        p_scl = 1'b1, p_sda = 1'b1;
    int          rise_cnt = 0, byte_cnt = 0, hi_cnt = 0;
    logic        rd_mode = 1'b0, hi_valid = 1'b0;
    logic [8:0]  frame = 9'h000;
    logic [7:0]  cur_sub = 8'h00;

    pullup (sda);
    assign sda = (slave_low && rst) ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_reader #(.QUARTER(Q)) dut (
        .clk(clk), .rst(rst), .start(start), .dev_id(dev_id), .sub_addr(sub_addr),
        .scl(scl), .sda(sda), .busy(busy), .done(done), .rdata(rdata),
        .ack_err(ack_err), .debug_out(debug_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Slave responder and bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            p_scl     <= scl;
            p_sda     <= sda;
            rise_cnt  <= 0;
            byte_cnt  <= 0;
            rd_mode   <= 1'b0;
            slave_low <= 1'b0;
            hi_valid  <= 1'b0;
            hi_cnt    <= 0;
        end else begin
            p_scl <= scl;
            p_sda <= sda;
            if (p_scl && scl) begin
                hi_cnt <= hi_cnt + 1;
                if (p_sda && !sda) begin
                    mon_q.push_back(EV_START);
                    rise_cnt  <= 0;
                    byte_cnt  <= 0;
                    rd_mode   <= 1'b0;
                    slave_low <= 1'b0;
                end else if (!p_sda && sda) begin
                    mon_q.push_back(EV_STOP);
                    slave_low <= 1'b0;
                end
            end else if (!p_scl && scl) begin
                hi_cnt   <= 1;
                hi_valid <= 1'b1;
                frame    <= {frame[7:0], sda};
                rise_cnt <= rise_cnt + 1;
            end else if (p_scl && !scl) begin
                hi_valid <= 1'b0;
                if (hi_valid && hi_cnt < 2 * Q) proto_err <= proto_err + 1;
                if (rise_cnt == 9) begin
                    mon_q.push_back(int'(frame));
                    rise_cnt <= 0;
                    byte_cnt <= byte_cnt + 1;
                    if (byte_cnt == 0 && frame[1]) begin
                        rd_mode   <= 1'b1;
                        slave_low <= ack_en && !mem[cur_sub][7];
                    end else begin
                        slave_low <= 1'b0;
                    end
                    if (byte_cnt == 1 && !rd_mode) cur_sub <= frame[8:1];
                end else if (rise_cnt == 8) begin
                    slave_low <= ack_en && !(rd_mode && byte_cnt == 1);
                end else if (rd_mode && byte_cnt == 1 && rise_cnt > 0) begin
                    slave_low <= ack_en && !mem[cur_sub][7 - rise_cnt];
                end
            end
        end
    end

    // One register read; called at a negedge. inj_at / rst_at < 0 disable those events.
    task automatic read_txn(input logic [7:0] id, input logic [7:0] sa, input logic ack,
                            input int inj_at, input int rst_at);
        int n, base, busy_drop, extra_done;
        int exp_q[$];
        logic [7:0] idw, exp_rd;
        ack_en = ack;
        base   = mon_q.size();
        idw    = {id[7:1], 1'b0};
        exp_rd = ack ? mem[sa] : 8'hFF;
        exp_q.push_back(EV_START);
        exp_q.push_back(int'({idw, ~ack}));
        exp_q.push_back(int'({sa, ~ack}));
        exp_q.push_back(EV_STOP);
        exp_q.push_back(EV_START);
        exp_q.push_back(int'({idw | 8'h01, ~ack}));
        exp_q.push_back(int'({exp_rd, 1'b1}));
        exp_q.push_back(EV_STOP);

        dev_id = id; sub_addr = sa; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_accept", busy, 1);
        check_eq("ack_err_clear", ack_err, 0);
        n = 0; busy_drop = 0;
        while (n < LAT + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
            if (!busy) busy_drop++;
            if (n == 50) check_eq("rdata_hold", rdata, last_rdata);
            if (n == inj_at) begin
                start = 1'b1; dev_id = 8'h99; sub_addr = 8'h33;
            end else if (n == inj_at + 1) begin
                start = 1'b0; dev_id = id; sub_addr = sa;
            end
            if (n == rst_at) begin
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_eq("rst_scl", scl, 1);
                check_eq("rst_sda", sda, 1);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_state", debug_out[31:28], 0);
                check_eq("rst_rdata", rdata, 0);
                @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                last_rdata = 8'h00;
                return;
            end
        end
        check_eq("latency", n, LAT);
        check_eq("busy_held", busy_drop, 0);
        check_eq("busy_at_done", busy, 0);
        check_eq("rdata", rdata, exp_rd);
        check_eq("ack_err", ack_err, !ack);
        check_eq("frame_cnt", mon_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < mon_q.size()) check_eq("frame", mon_q[base + i], exp_q[i]);
        end
        check_eq("protocol", proto_err, 0);
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        last_rdata = exp_rd;
        if (inj_at >= 0) begin
            extra_done = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done || busy) extra_done++;
            end
            check_eq("single_done", extra_done, 0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; dev_id = 8'h00; sub_addr = 8'h00;
        ack_en = 1'b1; last_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h0A] = 8'h76;
        mem[8'h0B] = 8'hA5;
        repeat (3) @(negedge clk);
        check_eq("reset_scl", scl, 1);
        check_eq("reset_sda", sda, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_rdata", rdata, 0);
        check_eq("reset_ack_err", ack_err, 0);
        check_eq("reset_debug", debug_out, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        read_txn(8'h42, 8'h0A, 1'b1, -1, -1);
        read_txn(8'h42, 8'h0B, 1'b1, -1, -1);
        repeat (5) @(negedge clk);
        read_txn(8'h42, 8'h0A, 1'b0, -1, -1);
        read_txn(8'h43, 8'h0A, 1'b1, 100, -1);
        read_txn(8'h42, 8'h0A, 1'b1, -1, 300);
        read_txn(8'h42, 8'h0A, 1'b1, -1, -1);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            read_txn(8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
